// File: rtl/alu_if.sv
// alu_if: operand/result bundle between an ALU producer (master) and the ALU (slave).
//   in_valid, a, b, op : operands and opcode, driven by master
//   out_valid, result, err : registered result, driven by slave
interface alu_if;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       out_valid;
    logic [7:0] result;
    logic       err;

    modport master (output in_valid, a, b, op, input out_valid, result, err);
    modport slave  (input in_valid, a, b, op, output out_valid, result, err);
endinterface

// File: rtl/alu.sv
// alu: 4-bit unsigned add/mul/mod/and with an 8-bit registered result, 1-cycle latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_if.slave (in_valid, a, b, op in; out_valid, result, err out)
//   op 00 add, 01 multiply, 10 modulo, 11 bitwise AND
//   Define ALU_MOD_EN to build the modulo path; otherwise op=10 returns 0 with err=1.
module alu (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    logic [7:0] result_d, result_q;
    logic       err_d, err_q, valid_q;
    logic [7:0] mod_res;
    logic       mod_err;

`ifdef ALU_MOD_EN
    assign mod_err = (bus.b == 4'd0);
    assign mod_res = mod_err ? 8'd0 : {4'b0, bus.a % bus.b};
`else
    assign mod_err = 1'b1;
    assign mod_res = 8'd0;
`endif

    always_comb begin
        result_d = (bus.op == 2'b00) ? {4'b0, bus.a} + {4'b0, bus.b} :
                   (bus.op == 2'b01) ? {4'b0, bus.a} * {4'b0, bus.b} :
                   (bus.op == 2'b10) ? mod_res :
                                       {4'b0, bus.a & bus.b};
        err_d    = (bus.op == 2'b10) && mod_err;
    end

    // result/err only load on in_valid so they hold the last answer while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 8'd0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= result_d;
                err_q    <= err_d;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu.
module tb_alu;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
    endtask

    task automatic outs(input string tag, input logic v, input logic [7:0] r, input logic e);
        cmp({tag, ".valid"}, {7'b0, bus.out_valid}, {7'b0, v});
        cmp({tag, ".result"}, bus.result, r);
        cmp({tag, ".err"}, {7'b0, bus.err}, {7'b0, e});
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] r, input logic e);
        @(posedge clk);
        #1;
        outs(tag, v, r, e);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a  = 4'd0;
        bus.b  = 4'd0;
        bus.op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        outs("reset", 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 4'd1, 4'd2, 2'b00);    step("add1", 1, 8'd3, 0);
        drive(1, 4'd15, 4'd15, 2'b00);  step("add_max", 1, 8'd30, 0);
        drive(1, 4'd14, 4'd10, 2'b01);  step("mul1", 1, 8'd140, 0);
        drive(1, 4'd1, 4'd0, 2'b01);    step("mul_zero", 1, 8'd0, 0);
        drive(1, 4'd15, 4'd15, 2'b01);  step("mul_max", 1, 8'd225, 0);
`ifdef ALU_MOD_EN
        drive(1, 4'd3, 4'd2, 2'b10);    step("mod1", 1, 8'd1, 0);
        drive(1, 4'd12, 4'd3, 2'b10);   step("mod2", 1, 8'd0, 0);
        drive(1, 4'd4, 4'd2, 2'b10);    step("mod3", 1, 8'd0, 0);
        drive(1, 4'd5, 4'd0, 2'b10);    step("mod_by0", 1, 8'd0, 1);
`else
        drive(1, 4'd3, 4'd2, 2'b10);    step("mod_dis1", 1, 8'd0, 1);
        drive(1, 4'd15, 4'd7, 2'b10);   step("mod_dis2", 1, 8'd0, 1);
`endif
        drive(1, 4'd12, 4'd10, 2'b11);  step("and1", 1, 8'd8, 0);
        drive(1, 4'd15, 4'd15, 2'b11);  step("and_upper0", 1, 8'd15, 0);
        drive(1, 4'd4, 4'd3, 2'b11);    step("and_zero", 1, 8'd0, 0);

        drive(0, 4'd0, 4'd0, 2'b00);    step("gap", 0, 8'd0, 0);
        drive(1, 4'd3, 4'd1, 2'b00);    step("b2b1", 1, 8'd4, 0);
        drive(1, 4'd2, 4'd1, 2'b01);    step("b2b2", 1, 8'd2, 0);
        drive(1, 4'd3, 4'd3, 2'b11);    step("b2b3", 1, 8'd3, 0);
        drive(0, 4'd9, 4'd9, 2'b01);    step("idle1", 0, 8'd3, 0);
        step("idle2", 0, 8'd3, 0);

        drive(1, 4'd14, 4'd10, 2'b01);
        @(posedge clk);
        #1;
        outs("inflight", 1, 8'd140, 0);
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        outs("async_rst", 0, 8'd0, 0);
        drive(1, 4'd14, 4'd10, 2'b01);
        step("in_rst", 0, 8'd0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step("post_rst", 0, 8'd0, 0);
        drive(1, 4'd1, 4'd2, 2'b00);    step("first_after", 1, 8'd3, 0);
        drive(0, 4'd0, 4'd0, 2'b00);    step("end_idle", 0, 8'd3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
